// File: rtl/hack_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hack_key_decoder : PS/2 Set-2 bytes to Hack KBD code, with held-key stack |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module hack_key_decoder #(
   parameter int CODE_W        = 16,
   parameter int HOLD_DEPTH    = 4,
   parameter int CASE_MODE     = 1,
   parameter int KEYPAD_ARROWS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        scan_code,
   input  logic              got_code,
   output logic [CODE_W-1:0] hack_code,
   output logic              key_valid,
   output logic              caps_lock
);

   localparam int CNT_W = $clog2(HOLD_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_SKIP    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       skip_q, skip_d;
   logic [8:0]       stk_q [HOLD_DEPTH];
   logic [8:0]       stk_d [HOLD_DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lsh_q, lsh_d, rsh_q, rsh_d;
   logic             caps_q, caps_d, held_q, held_d;
   logic             push_q, push_d;
   logic             valid_q;
   logic [7:0]       hack_q;

   logic             ev_make, ev_brk;
   logic [8:0]       ev_id;
   logic             hit;
   logic [CNT_W-1:0] hit_idx;
   logic [8:0]       top_id;

   // Letter position 1..26 (A..Z); 0 means not a letter.
   function automatic logic [4:0] letter_idx(input logic [7:0] b);
      case (b)
         8'h1C: return 5'd1;
         8'h32: return 5'd2;
         8'h21: return 5'd3;
         8'h23: return 5'd4;
         8'h24: return 5'd5;
         8'h2B: return 5'd6;
         8'h34: return 5'd7;
         8'h33: return 5'd8;
         8'h43: return 5'd9;
         8'h3B: return 5'd10;
         8'h42: return 5'd11;
         8'h4B: return 5'd12;
         8'h3A: return 5'd13;
         8'h31: return 5'd14;
         8'h44: return 5'd15;
         8'h4D: return 5'd16;
         8'h15: return 5'd17;
         8'h2D: return 5'd18;
         8'h1B: return 5'd19;
         8'h2C: return 5'd20;
         8'h3C: return 5'd21;
         8'h2A: return 5'd22;
         8'h1D: return 5'd23;
         8'h22: return 5'd24;
         8'h35: return 5'd25;
         8'h1A: return 5'd26;
         default: return 5'd0;
      endcase
   endfunction

   // Digit value plus one (1 = '0' .. 10 = '9'); 0 means not a digit.
   function automatic logic [3:0] digit_idx(input logic [7:0] b);
      case (b)
         8'h45: return 4'd1;
         8'h16: return 4'd2;
         8'h1E: return 4'd3;
         8'h26: return 4'd4;
         8'h25: return 4'd5;
         8'h2E: return 4'd6;
         8'h36: return 4'd7;
         8'h3D: return 4'd8;
         8'h3E: return 4'd9;
         8'h46: return 4'd10;
         default: return 4'd0;
      endcase
   endfunction

   // Zero result marks an unmapped key id.
   function automatic logic [7:0] xlate(input logic [8:0] id, input logic shf, input logic cap);
      logic [7:0] c;
      logic [4:0] li;
      logic [3:0] dv;
      c  = 8'd0;
      li = letter_idx(id[7:0]);
      dv = digit_idx(id[7:0]);
      if (!id[8] && li != 5'd0) begin
         c = 8'd64 + {3'b000, li};
         if (CASE_MODE != 0 && !(shf ^ cap)) c = c + 8'd32;
      end else if (!id[8] && dv != 4'd0) begin
         if (CASE_MODE != 0 && shf) begin
            case (dv)
               4'd1:    c = 8'd41;
               4'd2:    c = 8'd33;
               4'd3:    c = 8'd64;
               4'd4:    c = 8'd35;
               4'd5:    c = 8'd36;
               4'd6:    c = 8'd37;
               4'd7:    c = 8'd94;
               4'd8:    c = 8'd38;
               4'd9:    c = 8'd42;
               default: c = 8'd40;
            endcase
         end else begin
            c = 8'd47 + {4'b0000, dv};
         end
      end else begin
         case (id)
            9'h029:          c = 8'd32;
            9'h05A, 9'h15A:  c = 8'd128;
            9'h066:          c = 8'd129;
            9'h16B:          c = 8'd130;
            9'h175:          c = 8'd131;
            9'h174:          c = 8'd132;
            9'h172:          c = 8'd133;
            9'h06B:          c = (KEYPAD_ARROWS != 0) ? 8'd130 : 8'd0;
            9'h075:          c = (KEYPAD_ARROWS != 0) ? 8'd131 : 8'd0;
            9'h074:          c = (KEYPAD_ARROWS != 0) ? 8'd132 : 8'd0;
            9'h072:          c = (KEYPAD_ARROWS != 0) ? 8'd133 : 8'd0;
            9'h16C:          c = 8'd134;
            9'h169:          c = 8'd135;
            9'h17D:          c = 8'd136;
            9'h17A:          c = 8'd137;
            9'h170:          c = 8'd138;
            9'h171:          c = 8'd139;
            9'h076:          c = 8'd140;
            9'h005:          c = 8'd141;
            9'h006:          c = 8'd142;
            9'h004:          c = 8'd143;
            9'h00C:          c = 8'd144;
            9'h003:          c = 8'd145;
            9'h00B:          c = 8'd146;
            9'h083:          c = 8'd147;
            9'h00A:          c = 8'd148;
            9'h001:          c = 8'd149;
            9'h009:          c = 8'd150;
            9'h078:          c = 8'd151;
            9'h007:          c = 8'd152;
            default:         c = 8'd0;
         endcase
      end
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      ev_make = 1'b0;
      ev_brk  = 1'b0;
      ev_id   = 9'd0;
      if (got_code) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == 8'hF0) begin
                  state_d = ST_BRK;
               end else if (scan_code == 8'hE0) begin
                  state_d = ST_EXT;
               end else if (scan_code == 8'hE1) begin
                  state_d = ST_SKIP;
                  skip_d  = 3'd7;
               end else begin
                  ev_make = 1'b1;
                  ev_id   = {1'b0, scan_code};
               end
            end
            ST_EXT: begin
               if (scan_code == 8'hF0) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  ev_make = 1'b1;
                  ev_id   = {1'b1, scan_code};
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               ev_brk  = 1'b1;
               ev_id   = {1'b0, scan_code};
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               ev_brk  = 1'b1;
               ev_id   = {1'b1, scan_code};
               state_d = ST_IDLE;
            end
            ST_SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      top_id  = 9'd0;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
         if (CNT_W'(i) < cnt_q && stk_q[i] == ev_id) begin
            hit     = 1'b1;
            hit_idx = CNT_W'(i);
         end
         if (CNT_W'(i + 1) == cnt_q) top_id = stk_q[i];
      end
   end

   always_comb begin
      stk_d  = stk_q;
      cnt_d  = cnt_q;
      lsh_d  = lsh_q;
      rsh_d  = rsh_q;
      caps_d = caps_q;
      held_d = held_q;
      push_d = 1'b0;
      if (ev_make) begin
         if (ev_id == 9'h012) begin
            lsh_d = 1'b1;
         end else if (ev_id == 9'h059) begin
            rsh_d = 1'b1;
         end else if (ev_id == 9'h058) begin
            // Typematic repeats of Caps Lock must not re-toggle.
            if (!held_q) begin
               caps_d = ~caps_q;
               held_d = 1'b1;
            end
         end else if (xlate(ev_id, 1'b0, 1'b0) != 8'd0 && !hit) begin
            push_d = 1'b1;
            if (cnt_q == CNT_W'(HOLD_DEPTH)) begin
               for (int i = 0; i < HOLD_DEPTH - 1; i++) stk_d[i] = stk_q[i + 1];
               stk_d[HOLD_DEPTH - 1] = ev_id;
            end else begin
               for (int i = 0; i < HOLD_DEPTH; i++) begin
                  if (CNT_W'(i) == cnt_q) stk_d[i] = ev_id;
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end else if (ev_brk) begin
         if (ev_id == 9'h012) begin
            lsh_d = 1'b0;
         end else if (ev_id == 9'h059) begin
            rsh_d = 1'b0;
         end else if (ev_id == 9'h058) begin
            held_d = 1'b0;
         end else if (hit) begin
            for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
               if (CNT_W'(i) >= hit_idx) stk_d[i] = stk_q[i + 1];
            end
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         skip_q  <= 3'd0;
         for (int i = 0; i < HOLD_DEPTH; i++) stk_q[i] <= 9'd0;
         cnt_q   <= '0;
         lsh_q   <= 1'b0;
         rsh_q   <= 1'b0;
         caps_q  <= 1'b0;
         held_q  <= 1'b0;
         push_q  <= 1'b0;
         valid_q <= 1'b0;
         hack_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         stk_q   <= stk_d;
         cnt_q   <= cnt_d;
         lsh_q   <= lsh_d;
         rsh_q   <= rsh_d;
         caps_q  <= caps_d;
         held_q  <= held_d;
         push_q  <= push_d;
         valid_q <= push_q;
         hack_q  <= (cnt_q == '0) ? 8'd0 : xlate(top_id, lsh_q | rsh_q, caps_q);
      end
   end

   generate
      if (CODE_W > 8) begin : g_wide
         assign hack_code = {{(CODE_W - 8){1'b0}}, hack_q};
      end else begin : g_exact
         assign hack_code = hack_q;
      end
   endgenerate

   assign key_valid = valid_q;
   assign caps_lock = caps_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hack_key_decoder : directed bench, default and legacy configurations  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hack_key_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  scan_code = 8'd0;
   logic        got_code = 1'b0;
   logic [15:0] hack_code;
   logic        key_valid, caps_lock;
   logic [7:0]  leg_code;
   logic        leg_valid, leg_caps;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   hack_key_decoder u_main (
      .clk(clk), .reset(reset), .scan_code(scan_code), .got_code(got_code),
      .hack_code(hack_code), .key_valid(key_valid), .caps_lock(caps_lock)
   );

   // Legacy casing, no keypad arrows, shallow stack, 8-bit output.
   hack_key_decoder #(.CODE_W(8), .HOLD_DEPTH(2), .CASE_MODE(0), .KEYPAD_ARROWS(0)) u_leg (
      .clk(clk), .reset(reset), .scan_code(scan_code), .got_code(got_code),
      .hack_code(leg_code), .key_valid(leg_valid), .caps_lock(leg_caps)
   );

   // Called at a falling edge; consecutive calls produce back-to-back strobes.
   task automatic send(input logic [7:0] b);
      scan_code = b;
      got_code  = 1'b1;
      @(negedge clk);
      got_code  = 1'b0;
   endtask

   task automatic pulse_reset();
      reset    = 1'b1;
      got_code = 1'b0;
      @(negedge clk);
      reset    = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      pulse_reset();
      checks++;
      if (hack_code !== 16'd0 || key_valid !== 1'b0 || caps_lock !== 1'b0) begin
         $display("FAIL reset_state code=%0d kv=%b caps=%b exp 0/0/0", hack_code, key_valid, caps_lock);
         errors++;
      end
   endtask

   task automatic test_case();
      pulse_reset();
      send(8'h1C);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd97 || key_valid !== 1'b1) begin
         $display("FAIL a_lower code=%0d kv=%b exp 97/1", hack_code, key_valid);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0) begin
         $display("FAIL kv_single_pulse kv=%b exp 0", key_valid);
         errors++;
      end
      send(8'h12);
      send(8'h1C);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd65 || key_valid !== 1'b0) begin
         $display("FAIL a_shifted_repeat code=%0d kv=%b exp 65/0", hack_code, key_valid);
         errors++;
      end
      send(8'hF0);
      send(8'h1C);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd0) begin
         $display("FAIL a_release code=%0d exp 0", hack_code);
         errors++;
      end
   endtask

   task automatic test_overlay();
      pulse_reset();
      send(8'h1C);
      send(8'h32);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd98) begin
         $display("FAIL b_on_a code=%0d exp 98", hack_code);
         errors++;
      end
      send(8'hF0);
      send(8'h32);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd97) begin
         $display("FAIL reveal_a code=%0d exp 97", hack_code);
         errors++;
      end
      send(8'hF0);
      send(8'h1C);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd0) begin
         $display("FAIL overlay_empty code=%0d exp 0", hack_code);
         errors++;
      end
   endtask

   task automatic test_depth();
      pulse_reset();
      send(8'h1C);
      send(8'h32);
      send(8'h21);
      send(8'h23);
      send(8'h24);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd101) begin
         $display("FAIL depth_top_e code=%0d exp 101", hack_code);
         errors++;
      end
      send(8'hF0);
      send(8'h24);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd100) begin
         $display("FAIL depth_reveal_d code=%0d exp 100", hack_code);
         errors++;
      end
      send(8'hF0);
      send(8'h1C);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd100) begin
         $display("FAIL depth_dropped_a code=%0d exp 100", hack_code);
         errors++;
      end
      send(8'h59);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd68) begin
         $display("FAIL rshift_live code=%0d exp 68", hack_code);
         errors++;
      end
      send(8'hF0);
      send(8'h59);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd100) begin
         $display("FAIL rshift_release code=%0d exp 100", hack_code);
         errors++;
      end
   endtask

   task automatic test_ext();
      pulse_reset();
      send(8'hE0);
      send(8'h75);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd131) begin
         $display("FAIL ext_up code=%0d exp 131", hack_code);
         errors++;
      end
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd0) begin
         $display("FAIL ext_up_release code=%0d exp 0", hack_code);
         errors++;
      end
      send(8'h75);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd131 || leg_code !== 8'd0) begin
         $display("FAIL keypad_up main=%0d leg=%0d exp 131/0", hack_code, leg_code);
         errors++;
      end
      send(8'hE0);
      send(8'h12);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd131 || key_valid !== 1'b0) begin
         $display("FAIL fake_shift code=%0d kv=%b exp 131/0", hack_code, key_valid);
         errors++;
      end
      send(8'h07);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd152 || leg_code !== 8'd152) begin
         $display("FAIL f12 main=%0d leg=%0d exp 152/152", hack_code, leg_code);
         errors++;
      end
      send(8'hE0);
      send(8'h5A);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd128) begin
         $display("FAIL ext_enter code=%0d exp 128", hack_code);
         errors++;
      end
   endtask

   task automatic test_pause();
      pulse_reset();
      send(8'h1C);
      send(8'hE1);
      send(8'h14);
      send(8'h77);
      send(8'hE1);
      send(8'hF0);
      send(8'h14);
      send(8'hF0);
      send(8'h77);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd97 || caps_lock !== 1'b0) begin
         $display("FAIL pause_discard code=%0d caps=%b exp 97/0", hack_code, caps_lock);
         errors++;
      end
      send(8'h58);
      send(8'h58);
      send(8'hF0);
      send(8'h58);
      @(negedge clk);
      checks++;
      if (caps_lock !== 1'b1 || hack_code !== 16'd65) begin
         $display("FAIL caps_once caps=%b code=%0d exp 1/65", caps_lock, hack_code);
         errors++;
      end
      send(8'h32);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd66 || key_valid !== 1'b1 || leg_code !== 8'd66) begin
         $display("FAIL caps_b main=%0d kv=%b leg=%0d exp 66/1/66", hack_code, key_valid, leg_code);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      send(8'hF0);
      pulse_reset();
      send(8'h16);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd49 || key_valid !== 1'b1) begin
         $display("FAIL make_after_reset code=%0d kv=%b exp 49/1", hack_code, key_valid);
         errors++;
      end
      send(8'h12);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd33 || leg_code !== 8'd49) begin
         $display("FAIL shift_digit main=%0d leg=%0d exp 33/49", hack_code, leg_code);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      send(8'h1C);
      send(8'h32);
      checks++;
      if (hack_code !== 16'd97 || key_valid !== 1'b1) begin
         $display("FAIL b2b_first code=%0d kv=%b exp 97/1", hack_code, key_valid);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd98 || key_valid !== 1'b1) begin
         $display("FAIL b2b_second code=%0d kv=%b exp 98/1", hack_code, key_valid);
         errors++;
      end
      send(8'hE0);
      send(8'h6C);
      send(8'h21);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd99 || leg_code !== 8'd67) begin
         $display("FAIL b2b_c main=%0d leg=%0d exp 99/67", hack_code, leg_code);
         errors++;
      end
      send(8'hF0);
      send(8'h21);
      @(negedge clk);
      checks++;
      if (hack_code !== 16'd134 || leg_code !== 8'd134) begin
         $display("FAIL b2b_home main=%0d leg=%0d exp 134/134", hack_code, leg_code);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_case();
      test_overlay();
      test_depth();
      test_ext();
      test_pause();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
